// File: rtl/multiword_add_sequencer.sv
// Multi-cycle (N*K)-bit adder controller driving one external N-bit combinational adder.
// Define MWADD_SIGNED_OVF_EN to add the out_ovf signed-overflow output.
module multiword_add_sequencer #(
  parameter int unsigned N = 32,
  parameter int unsigned K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] in_a,
  input  logic [N*K-1:0] in_b,
  input  logic           in_ci,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] out_c,
  output logic           out_co,
`ifdef MWADD_SIGNED_OVF_EN
  output logic           out_ovf,
`endif
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_ci,
  input  logic [N-1:0]   add_c,
  input  logic           add_co
);

  localparam int unsigned W    = N * K;
  localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(K - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            ci_q, ci_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    res_q, res_d;
  logic            co_q, co_d;
`ifdef MWADD_SIGNED_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    ci_d      = ci_q;
    carry_d   = carry_q;
    res_d     = res_q;
    co_d      = co_q;
`ifdef MWADD_SIGNED_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_ci    = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          ci_d    = in_ci;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        add_a   = a_q[idx_q*N +: N];
        add_b   = b_q[idx_q*N +: N];
        // First chunk takes the external carry, later chunks chain the adder's carry.
        add_ci  = (idx_q == '0) ? ci_q : carry_q;
        res_d[idx_q*N +: N] = add_c;
        carry_d = add_co;
        if (idx_q == LastIdx) begin
          co_d    = add_co;
`ifdef MWADD_SIGNED_OVF_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_c[N-1] != a_q[W-1]);
`endif
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= '0;
      co_q    <= 1'b0;
`ifdef MWADD_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      co_q    <= co_d;
`ifdef MWADD_SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_c  = res_q;
  assign out_co = co_q;
`ifdef MWADD_SIGNED_OVF_EN
  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer: a 32x4 instance and an 8x1 instance,
// each paired with a behavioural N-bit adder.
module tb_multiword_add_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 32x4 instance
  logic         in_valid, in_ready, in_ci, out_valid, out_ready, out_co;
  logic [127:0] in_a, in_b, out_c;
  logic [31:0]  add_a, add_b, add_c;
  logic         add_ci, add_co;
`ifdef MWADD_SIGNED_OVF_EN
  logic         out_ovf;
`endif
  assign {add_co, add_c} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};

  multiword_add_sequencer #(.N(32), .K(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_co    (out_co),
`ifdef MWADD_SIGNED_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_c     (add_c),
    .add_co    (add_co)
  );

  // 8x1 instance
  logic       in_valid1, in_ready1, in_ci1, out_valid1, out_ready1, out_co1;
  logic [7:0] in_a1, in_b1, out_c1, add_a1, add_b1, add_c1;
  logic       add_ci1, add_co1;
`ifdef MWADD_SIGNED_OVF_EN
  logic       out_ovf1;
`endif
  assign {add_co1, add_c1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'd0, add_ci1};

  multiword_add_sequencer #(.N(8), .K(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .in_ci     (in_ci1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_c     (out_c1),
    .out_co    (out_co1),
`ifdef MWADD_SIGNED_OVF_EN
    .out_ovf   (out_ovf1),
`endif
    .add_a     (add_a1),
    .add_b     (add_b1),
    .add_ci    (add_ci1),
    .add_c     (add_c1),
    .add_co    (add_co1)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set for a single edge; assumes the DUT is idle.
  task automatic issue(input logic [127:0] a, input logic [127:0] b, input logic ci);
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Edges until out_valid, or -1 if the bound expires.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_c !== 128'd0 || out_co !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_c=%h out_co=%b, want 1 0 0 0",
               in_ready, out_valid, out_c, out_co);
    end
    checks++;
    if (add_a !== 32'd0 || add_b !== 32'd0 || add_ci !== 1'b0 || in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_adder_drive: add_a=%h add_b=%h add_ci=%b in_ready1=%b, want 0 0 0 1",
               add_a, add_b, add_ci, in_ready1);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_carry_chain();
    int n;
    out_ready = 1'b1;
    issue(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0);
    checks++;
    if (add_a !== 32'hFFFF_FFFF || add_b !== 32'd1 || add_ci !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL chunk0_drive: add_a=%h add_b=%h add_ci=%b in_ready=%b, want ffffffff 1 0 0",
               add_a, add_b, add_ci, in_ready);
    end
    step();
    checks++;
    if (add_a !== 32'd0 || add_b !== 32'd0 || add_ci !== 1'b1) begin
      failures++;
      $display("FAIL chunk1_drive: add_a=%h add_b=%h add_ci=%b, want 0 0 1", add_a, add_b, add_ci);
    end
    wait_valid(n);
    // accept edge + K edges: valid in the cycle after the last chunk
    checks++;
    if (n + 1 !== 4) begin
      failures++;
      $display("FAIL carry_latency: edges_after_accept=%0d, want 4", n + 1);
    end
    checks++;
    if (out_c !== 128'h0000_0000_0000_0000_0000_0001_0000_0000 || out_co !== 1'b0) begin
      failures++;
      $display("FAIL carry_result: out_c=%h out_co=%b, want 100000000 0", out_c, out_co);
    end
    checks++;
    if (add_a !== 32'd0 || add_ci !== 1'b0) begin
      failures++;
      $display("FAIL done_adder_idle: add_a=%h add_ci=%b, want 0 0", add_a, add_ci);
    end
    step();
  endtask

  task automatic test_wrap();
    int n;
    issue({128{1'b1}}, 128'd0, 1'b1);
    wait_valid(n);
    checks++;
    if (n < 0 || out_c !== 128'd0 || out_co !== 1'b1) begin
      failures++;
      $display("FAIL wrap_result: n=%0d out_c=%h out_co=%b, want 0 1", n, out_c, out_co);
    end
`ifdef MWADD_SIGNED_OVF_EN
    checks++;
    if (out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL wrap_ovf: out_ovf=%b, want 0", out_ovf);
    end
`endif
    step();
  endtask

  task automatic test_signed_ovf();
    int n;
    issue({1'b0, {127{1'b1}}}, 128'd1, 1'b0);
    wait_valid(n);
    checks++;
    if (n < 0 || out_c !== {1'b1, 127'd0} || out_co !== 1'b0) begin
      failures++;
      $display("FAIL ovf_result: n=%0d out_c=%h out_co=%b, want 8000..0 0", n, out_c, out_co);
    end
`ifdef MWADD_SIGNED_OVF_EN
    checks++;
    if (out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag: out_ovf=%b, want 1", out_ovf);
    end
`endif
    step();
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    out_ready = 1'b0;
    issue(128'd10, 128'd20, 1'b0);
    wait_valid(n);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = {4{32'hDEAD_BEEF}} + 128'(i);
      in_b = {4{32'h1234_5678}};
      step();
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_c !== 128'd30) bad++;
    end
    checks++;
    if (n < 0 || bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold: n=%0d bad_cycles=%0d out_c=%h, want 0 bad, out_c 1e",
               n, bad, out_c);
    end
    in_a = 128'h0000_0001_0000_0000_0000_0000_0000_0003;
    in_b = 128'h0000_0002_0000_0000_0000_0000_0000_0004;
    in_ci = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_ready: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    step();
    in_valid = 1'b0;
    in_a = {128{1'b1}};
    in_b = {128{1'b1}};
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL queued_accept: in_ready=%b, want 0", in_ready);
    end
    wait_valid(n);
    checks++;
    if (n < 0 || out_c !== 128'h0000_0003_0000_0000_0000_0000_0000_0007 || out_co !== 1'b0) begin
      failures++;
      $display("FAIL queued_result: n=%0d out_c=%h out_co=%b, want 3_0..0_7 0", n, out_c, out_co);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    int n;
    int seen;
    issue({128{1'b1}}, 128'd1, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_c !== 128'd0) begin
      failures++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b out_c=%h, want 1 0 0",
               in_ready, out_valid, out_c);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midrun_no_valid: valid_cycles=%0d, want 0", seen);
    end
    issue(128'd5, 128'd7, 1'b0);
    wait_valid(n);
    checks++;
    if (n < 0 || out_c !== 128'd12 || out_co !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_op: n=%0d out_c=%h out_co=%b, want c 0", n, out_c, out_co);
    end
    step();
  endtask

  task automatic test_k1();
    int n;
    int cnt;
    int last;
    int gap_bad;
    out_ready1 = 1'b1;
    in_a1 = 8'hFF; in_b1 = 8'h01; in_ci1 = 1'b0; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== 1 || out_c1 !== 8'h00 || out_co1 !== 1'b1) begin
      failures++;
      $display("FAIL k1_add: edges=%0d out_c=%h out_co=%b, want 1 00 1", n, out_c1, out_co1);
    end
    step();
    in_a1 = 8'h10; in_b1 = 8'h22; in_valid1 = 1'b1;
    cnt = 0;
    last = -1;
    gap_bad = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (out_valid1 === 1'b1) begin
        if (last >= 0 && i - last != 3) gap_bad++;
        if (out_c1 !== 8'h32 || out_co1 !== 1'b0) gap_bad++;
        last = i;
        cnt++;
      end
    end
    in_valid1 = 1'b0;
    checks++;
    if (cnt != 3 || gap_bad != 0) begin
      failures++;
      $display("FAIL k1_back_to_back: results=%0d bad=%0d, want 3 0", cnt, gap_bad);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_ci1 = 1'b0; out_ready1 = 1'b0;
    test_reset();
    test_carry_chain();
    test_wrap();
    test_signed_ovf();
    test_backpressure();
    test_reset_mid_run();
    test_k1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
